// File: rtl/gaussian_window_ctrl.sv
// Row/column tracker and border/interior decision for the 3x3 Gaussian filter; window flag 1 cycle,
// output-mux select PIPE_LAT cycles after the pixel; no backpressure, the pixel stream is never stalled.
module gaussian_window_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int CW       = 12,
  parameter int RW       = 12,
  parameter int PIPE_LAT = 4
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_hsyn,
  input  logic          i_vsyn,
  input  logic          i_en,
  input  logic          i_filt_en,
  output logic [CW-1:0] o_col,
  output logic [RW-1:0] o_row,
  output logic          o_win_valid,
  output logic          o_sel_filt,
  output logic          o_frame_start,
  output logic          o_frame_err,
  output logic          o_busy
);

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  state_t               state, state_nxt;
  logic                 vs_d, en_d;
  logic                 vs_rise, en_fall;
  logic [CW-1:0]        col_cnt, col_nxt, col_out_nxt;
  logic [RW-1:0]        row_cnt, row_nxt, row_out_nxt;
  logic                 sticky, sticky_nxt;
  logic                 filt_lat, filt_nxt;
  logic                 fs_nxt, fe_nxt, win_cond;
  logic [PIPE_LAT-1:0]  sel_sr, sel_sr_nxt;
  logic                 hsyn_unused;

  // Line sync is redundant with the enable strobe; line ends are taken from en_fall.
  assign hsyn_unused = i_hsyn;

  assign vs_rise = i_vsyn & ~vs_d;
  assign en_fall = ~i_en & en_d;

  always_comb begin
    state_nxt   = state;
    col_nxt     = col_cnt;
    row_nxt     = row_cnt;
    sticky_nxt  = sticky;
    filt_nxt    = filt_lat;
    col_out_nxt = o_col;
    row_out_nxt = o_row;
    fs_nxt      = 1'b0;
    fe_nxt      = 1'b0;
    win_cond    = 1'b0;

    if (vs_rise) begin
      // Frame start wins over any pixel or line end in the same cycle.
      state_nxt  = ACTIVE;
      filt_nxt   = i_filt_en;
      fs_nxt     = 1'b1;
      fe_nxt     = (state == ACTIVE) && (sticky || (row_cnt != RW'(V_ACTIVE)));
      sticky_nxt = 1'b0;
      row_nxt    = '0;
      col_nxt    = '0;
      if (i_en) begin
        col_out_nxt = '0;
        row_out_nxt = '0;
        col_nxt     = CW'(1);
      end
    end else if (state == ACTIVE) begin
      win_cond = i_en && filt_lat && (row_cnt >= RW'(2)) && (col_cnt >= CW'(2));
      if (i_en) begin
        col_out_nxt = col_cnt;
        row_out_nxt = row_cnt;
        if (col_cnt != {CW{1'b1}})
          col_nxt = col_cnt + CW'(1);
      end else if (en_fall) begin
        if (col_cnt != CW'(H_ACTIVE))
          sticky_nxt = 1'b1;
        col_nxt = '0;
        if (row_cnt != {RW{1'b1}})
          row_nxt = row_cnt + RW'(1);
      end
    end

    sel_sr_nxt    = '0;
    sel_sr_nxt[0] = win_cond;
    for (int i = 1; i < PIPE_LAT; i++)
      sel_sr_nxt[i] = sel_sr[i-1];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state         <= IDLE;
      vs_d          <= 1'b0;
      en_d          <= 1'b0;
      col_cnt       <= '0;
      row_cnt       <= '0;
      sticky        <= 1'b0;
      filt_lat      <= 1'b0;
      o_col         <= '0;
      o_row         <= '0;
      o_win_valid   <= 1'b0;
      o_frame_start <= 1'b0;
      o_frame_err   <= 1'b0;
      sel_sr        <= '0;
    end else begin
      state         <= state_nxt;
      vs_d          <= i_vsyn;
      en_d          <= i_en;
      col_cnt       <= col_nxt;
      row_cnt       <= row_nxt;
      sticky        <= sticky_nxt;
      filt_lat      <= filt_nxt;
      o_col         <= col_out_nxt;
      o_row         <= row_out_nxt;
      o_win_valid   <= win_cond;
      o_frame_start <= fs_nxt;
      o_frame_err   <= fe_nxt;
      sel_sr        <= sel_sr_nxt;
    end
  end

  assign o_sel_filt = sel_sr[PIPE_LAT-1];
  assign o_busy     = (state == ACTIVE);

endmodule

// File: tb/tb_gaussian_window_ctrl.sv
// Scoreboard bench for gaussian_window_ctrl on a small 8x4 image with a 4-cycle filter pipe.
module tb_gaussian_window_ctrl;

  localparam int H  = 8;
  localparam int V  = 4;
  localparam int CW = 12;
  localparam int RW = 12;
  localparam int PL = 4;

  logic          i_clk = 1'b0;
  logic          i_rst, i_hsyn, i_vsyn, i_en, i_filt_en;
  logic [CW-1:0] o_col;
  logic [RW-1:0] o_row;
  logic          o_win_valid, o_sel_filt, o_frame_start, o_frame_err, o_busy;

  gaussian_window_ctrl #(
    .H_ACTIVE(H), .V_ACTIVE(V), .CW(CW), .RW(RW), .PIPE_LAT(PL)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_hsyn(i_hsyn), .i_vsyn(i_vsyn), .i_en(i_en),
    .i_filt_en(i_filt_en), .o_col(o_col), .o_row(o_row), .o_win_valid(o_win_valid),
    .o_sel_filt(o_sel_filt), .o_frame_start(o_frame_start), .o_frame_err(o_frame_err),
    .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model state (values before the coming edge)
  bit m_act, m_vsd, m_end, m_sticky, m_filt;
  int m_row, m_col;
  bit cur_filt;

  bit win_q[$];
  bit sel_q[$];
  int col_q[$];
  int row_q[$];

  int win_cnt, sel_cnt, fe_seen, fs_seen;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic do_reset(input int n);
    i_rst  = 1'b1;
    i_vsyn = 1'b0;
    i_en   = 1'b0;
    repeat (n) @(posedge i_clk);
    #1;
    chk("rst_col", o_col, 0);
    chk("rst_row", o_row, 0);
    chk("rst_win", o_win_valid, 0);
    chk("rst_sel", o_sel_filt, 0);
    chk("rst_fs", o_frame_start, 0);
    chk("rst_fe", o_frame_err, 0);
    chk("rst_busy", o_busy, 0);
    i_rst = 1'b0;
    m_act = 0; m_vsd = 0; m_end = 0; m_sticky = 0; m_filt = 0;
    m_row = 0; m_col = 0;
    win_q.delete(); sel_q.delete(); col_q.delete(); row_q.delete();
    for (int i = 0; i < PL - 1; i++) sel_q.push_back(1'b0);
  endtask

  task automatic step(input logic vs, input logic en);
    bit vr, ef, e_win, e_fs, e_fe, pix;
    vr    = vs & ~m_vsd;
    ef    = ~en & m_end;
    e_fs  = vr;
    e_fe  = vr & m_act & (m_sticky | (m_row != V));
    e_win = en & m_act & m_filt & (m_row >= 2) & (m_col >= 2) & ~vr;
    win_q.push_back(e_win);
    sel_q.push_back(e_win);
    pix = en & (m_act | vr);
    if (pix) begin
      col_q.push_back(vr ? 0 : m_col);
      row_q.push_back(vr ? 0 : m_row);
    end
    if (vr) begin
      m_act = 1; m_filt = cur_filt; m_sticky = 0; m_row = 0;
      m_col = en ? 1 : 0;
    end else if (m_act) begin
      if (en) m_col++;
      else if (ef) begin
        if (m_col != H) m_sticky = 1;
        m_col = 0;
        m_row++;
      end
    end
    m_vsd = vs;
    m_end = en;

    i_vsyn    = vs;
    i_en      = en;
    i_filt_en = cur_filt;
    @(posedge i_clk);
    #1;
    chk("frame_start", o_frame_start, e_fs);
    chk("frame_err", o_frame_err, e_fe);
    chk("busy", o_busy, m_act);
    chk("win_valid", o_win_valid, win_q.pop_front());
    chk("sel_filt", o_sel_filt, sel_q.pop_front());
    if (pix) begin
      chk("col", o_col, col_q.pop_front());
      chk("row", o_row, row_q.pop_front());
    end
    win_cnt += o_win_valid;
    sel_cnt += o_sel_filt;
    fe_seen += o_frame_err;
    fs_seen += o_frame_start;
  endtask

  // One frame of V lines; optional short line, mid-frame filter drop, pre-counted first pixel, abort by reset.
  task automatic frame(input int short_row, input int drop_row, input int start_col, input int abort_row);
    int n;
    win_cnt = 0;
    sel_cnt = 0;
    for (int r = 0; r < V; r++) begin
      if (r == drop_row) cur_filt = 1'b0;
      n = (r == short_row) ? H - 1 : H;
      if (r == 0) n -= start_col;
      if (!(r == 0 && start_col > 0)) repeat (2) step(1'b0, 1'b0);
      for (int c = 0; c < n; c++) begin
        if (r == abort_row && c == 3) begin
          do_reset(1);
          return;
        end
        step(1'b0, 1'b1);
      end
    end
    repeat (6) step(1'b0, 1'b0);
  endtask

  initial begin
    i_rst = 1'b1; i_hsyn = 1'b0; i_vsyn = 1'b0; i_en = 1'b0; i_filt_en = 1'b0;
    cur_filt = 1'b1;
    win_cnt = 0; sel_cnt = 0; fe_seen = 0; fs_seen = 0;
    do_reset(2);
    repeat (3) step(1'b0, 1'b0);

    step(1'b1, 1'b0);
    chk("first_fs_count", fs_seen, 1);

    frame(-1, -1, 0, -1);
    chk("clean_win_cnt", win_cnt, 12);
    chk("clean_sel_cnt", sel_cnt, 12);
    step(1'b1, 1'b0);
    chk("clean_no_err", fe_seen, 0);

    frame(1, -1, 0, -1);
    step(1'b1, 1'b0);
    chk("short_line_err", fe_seen, 1);

    frame(-1, 2, 0, -1);
    chk("drop_win_cnt", win_cnt, 12);
    chk("drop_sel_cnt", sel_cnt, 12);
    step(1'b1, 1'b0);
    chk("third_no_err", fe_seen, 1);

    frame(-1, -1, 0, -1);
    chk("bypass_win_cnt", win_cnt, 0);
    chk("bypass_sel_cnt", sel_cnt, 0);

    cur_filt = 1'b1;
    step(1'b1, 1'b1);
    frame(-1, -1, 1, -1);
    chk("coinc_win_cnt", win_cnt, 12);
    step(1'b1, 1'b0);
    chk("coinc_no_err", fe_seen, 1);

    frame(-1, -1, 0, 2);
    repeat (3) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    chk("post_rst_no_err", fe_seen, 1);
    frame(-1, -1, 0, -1);
    chk("post_rst_win_cnt", win_cnt, 12);
    step(1'b1, 1'b0);
    chk("final_no_err", fe_seen, 1);
    chk("fs_total", fs_seen, 8);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
